muldiv_unit: RTL and testbench



---
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and data bundle between the execute stage and the multiply/divide unit.
//   start      : request, sampled only while the unit is idle
//   muldiv_fn  : RV32M funct3 selecting the operation
//   a, b       : rs1 / rs2 operands
//   flush      : abort of the in-flight operation
//   busy       : operation in flight; the hazard unit stalls on it
//   done       : one-cycle pulse marking a valid result
//   result     : registered result, held until the next completion
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      muldiv_fn;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, muldiv_fn, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, muldiv_fn, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit.
// Multiplies by shift-add and divides by restoring division, one bit per
// cycle over XLEN iterations, then applies sign correction in a final cycle.
// Divide-by-zero and signed overflow complete on the accepting edge.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if slave (start, muldiv_fn, a, b, flush -> busy, done, result)
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [2:0]        op;
  logic              sign_a;
  logic              sign_b;
  // Multiply: {acc_hi, acc_lo} is the running product with the multiplier
  // shifting out of acc_lo. Divide: acc_hi is the partial remainder and acc_lo
  // shifts dividend bits out the top while quotient bits enter the bottom.
  logic [XLEN:0]     acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN-1:0]   opnd_b;
  logic              done_r;
  logic [XLEN-1:0]   result_r;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return -v;
  endfunction

  // MUL, MULH, MULHSU, DIV, REM treat rs1 as signed.
  function automatic logic a_is_signed(input logic [2:0] fn);
    return (fn == 3'b000) || (fn == 3'b001) || (fn == 3'b010) ||
           (fn == 3'b100) || (fn == 3'b110);
  endfunction

  // MUL, MULH, DIV, REM treat rs2 as signed.
  function automatic logic b_is_signed(input logic [2:0] fn);
    return (fn == 3'b000) || (fn == 3'b001) || (fn == 3'b100) || (fn == 3'b110);
  endfunction

  function automatic logic is_fast(input logic [2:0] fn, input logic [XLEN-1:0] x,
                                   input logic [XLEN-1:0] y);
    logic div_zero;
    logic ovf;
    div_zero = fn[2] && (y == '0);
    ovf      = fn[2] && !fn[0] && (x == MIN_NEG) && (y == ALL_ONES);
    return div_zero || ovf;
  endfunction

  // Architected results for the early-exit cases.
  function automatic logic [XLEN-1:0] fast_result(input logic [2:0] fn,
                                                  input logic [XLEN-1:0] x,
                                                  input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    if (y == '0) r = fn[1] ? x : ALL_ONES;
    else         r = fn[1] ? '0 : MIN_NEG;
    return r;
  endfunction

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] product_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  // Iteration datapath
  always_comb begin
    mul_sum   = {1'b0, acc_hi[XLEN-1:0]} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    div_shift = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_b});
  end

  // Sign correction and output select
  always_comb begin
    product     = {acc_hi[XLEN-1:0], acc_lo};
    product_fix = (sign_a ^ sign_b) ? -product : product;
    quot_fix    = (sign_a ^ sign_b) ? negate(acc_lo) : acc_lo;
    rem_fix     = sign_a ? negate(acc_hi[XLEN-1:0]) : acc_hi[XLEN-1:0];
    unique case (op)
      3'b000:                 fix_result = product_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = product_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quot_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      op       <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd_b   <= '0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        // Accept: fast path completes now, otherwise latch magnitudes
        IDLE: begin
          if (bus.start && !bus.flush) begin
            if (is_fast(bus.muldiv_fn, bus.a, bus.b)) begin
              result_r <= fast_result(bus.muldiv_fn, bus.a, bus.b);
              done_r   <= 1'b1;
            end else begin
              op      <= bus.muldiv_fn;
              sign_a  <= a_is_signed(bus.muldiv_fn) && bus.a[XLEN-1];
              sign_b  <= b_is_signed(bus.muldiv_fn) && bus.b[XLEN-1];
              acc_hi  <= '0;
              acc_lo  <= (a_is_signed(bus.muldiv_fn) && bus.a[XLEN-1]) ? negate(bus.a) : bus.a;
              opnd_b  <= (b_is_signed(bus.muldiv_fn) && bus.b[XLEN-1]) ? negate(bus.b) : bus.b;
              counter <= '0;
              state   <= CALC;
            end
          end
        end
        // One multiplier or quotient bit per cycle
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            if (op[2]) begin
              if (div_ge) begin
                acc_hi <= div_shift - {1'b0, opnd_b};
                acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
              end else begin
                acc_hi <= div_shift;
                acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
              end
            end else begin
              acc_hi <= {1'b0, mul_sum[XLEN:1]};
              acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
            if (counter == CNT_W'(XLEN - 1)) state <= FIX;
            counter <= counter + CNT_W'(1);
          end
        end
        // Sign fixup and completion; flush wins over completion
        FIX: begin
          if (!bus.flush) begin
            result_r <= fix_result;
            done_r   <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit with a behavioural model.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  bit   chk_en;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result computed with wide integer arithmetic.
  function automatic logic [31:0] ref_fn(input logic [2:0] fn, input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy, ux, uy, q;
    logic [63:0] p;
    bit ovf;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p = '0;
    case (fn)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = sx / sy; return q[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        q = ux / uy; return q[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        q = sx % sy; return q[31:0];
      end
      default: begin
        if (y == 0) return x;
        q = ux % uy; return q[31:0];
      end
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y);
    return fn[2] && ((y == 0) || (!fn[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Model: an accepted op occupies 33 busy cycles then completes; fast ops finish at once.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_result = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (bus.flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin m_done = 1'b1; m_result = m_pend; end
        end
      end else if (bus.start && !bus.flush) begin
        if (ref_fast(bus.muldiv_fn, bus.a, bus.b)) begin
          m_done = 1'b1; m_result = ref_fn(bus.muldiv_fn, bus.a, bus.b);
        end else begin
          m_left = 33; m_pend = ref_fn(bus.muldiv_fn, bus.a, bus.b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_left > 0));
      check("done", 32'(bus.done), 32'(m_done));
      check("result", bus.result, m_result);
    end
  end

  // Issues one op at the current falling edge; checks latency, busy span and result.
  task automatic do_op(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int exp_lat);
    int lat, busy_cnt;
    bit seen;
    bus.start = 1'b1; bus.muldiv_fn = fn; bus.a = x; bus.b = y;
    seen = 0; lat = 0; busy_cnt = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.muldiv_fn = 3'($urandom);
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin seen = 1; lat = n; end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", lat, exp_lat);
      check("busy_cycles", busy_cnt, exp_lat - 1);
      check("op_result", bus.result, exp);
    end
  endtask

  logic [2:0]  rfn;
  logic [31:0] rx, ry;
  int          dcnt;

  initial begin
    vectors = 0; miscompares = 0; chk_en = 0;
    bus.start = 0; bus.flush = 0; bus.muldiv_fn = '0; bus.a = '0; bus.b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    chk_en = 1;

    // Hand-computed values pinning the model
    check("model_mul", ref_fn(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model_mulh", ref_fn(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("model_mulhsu", ref_fn(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    check("model_mulhu", ref_fn(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("model_div", ref_fn(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem", ref_fn(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model_rem0", ref_fn(3'd6, 32'd5, 32'd0), 32'd5);

    @(negedge clk);
    // Fast path
    do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op(3'd6, 32'd5, 32'd0, 32'd5, 1);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    // Iterative ops, issued back to back in each done cycle
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 34);
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 34);

    // Flush at cycle 10 of a DIV
    bus.start = 1'b1; bus.muldiv_fn = 3'd4; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk); bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_flush", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0;
    check("busy_after_flush", 32'(bus.busy), 32'd0);
    dcnt = 0;
    repeat (40) begin @(negedge clk); if (bus.done) dcnt++; end
    check("flush_no_done", dcnt, 0);
    check("flush_result_held", bus.result, 32'd2);

    // Reset pulse mid-calculation
    bus.start = 1'b1; bus.muldiv_fn = 3'd0; bus.a = 32'd12345; bus.b = 32'd678;
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Start held through busy, operands changing after acceptance
    bus.start = 1'b1; bus.muldiv_fn = 3'd0; bus.a = 32'd3; bus.b = 32'd5;
    dcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 5) begin bus.a = 32'd9; bus.b = 32'd9; end
      if (bus.done) begin dcnt++; check("held_result", bus.result, 32'd15); end
      if (n == 34) bus.start = 1'b0;
    end
    check("held_one_done", dcnt, 1);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      int sel, k;
      rfn = 3'($urandom);
      sel = $urandom_range(0, 7);
      ry = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
           (sel == 2) ? 32'($urandom_range(1, 20)) : $urandom;
      sel = $urandom_range(0, 5);
      rx = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'($urandom_range(0, 100)) : $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        bus.start = 1'b1; bus.muldiv_fn = rfn; bus.a = rx; bus.b = ry;
        @(negedge clk); bus.start = 1'b0;
        k = $urandom_range(1, 33);
        repeat (k) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk); bus.flush = 1'b0;
        repeat (2) @(negedge clk);
      end else if (sel == 1) begin
        bus.start = 1'b1; bus.flush = 1'b1; bus.muldiv_fn = rfn; bus.a = rx; bus.b = ry;
        @(negedge clk); bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_drops_start", 32'(bus.busy | bus.done), 32'd0);
      end else begin
        do_op(rfn, rx, ry, ref_fn(rfn, rx, ry), ref_fast(rfn, rx, ry) ? 1 : 34);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
